instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
// - Fetch stage that feeds the 16/32-bit instruction decoder through fetchoutput.
// - Reads 16-bit words from instruction memory over a req/ack handshake.
// - Bit 15 of the first word selects 32-bit: 1 = a second word follows, 0 = 16-bit instruction.
// - Presents one whole instruction per valid/ready transfer. Accepts PC redirects from branch resolution.
// PARAMETERS
// - PC_WIDTH  16  word-address width. PC arithmetic is modulo 2^PC_WIDTH.
// - RESET_PC  0   PC loaded at reset (PC_WIDTH bits).
// PORTS
// - clock          in   1         rising-edge clock; the only clock
// - reset          in   1         synchronous, active-high
// - imem_req       out  1         memory read request
// - imem_addr      out  PC_WIDTH  word address; stable while imem_req is high and imem_ack is low
// - imem_ack       in   1         request accepted; imem_rdata valid in the same cycle
// - imem_rdata     in   16        read data
// - fetch_valid    out  1         fetchoutput/fetch_is32/fetch_pc hold a complete instruction
// - fetch_ready    in   1         decoder accepts the instruction this cycle
// - fetchoutput    out  32        [15:0] = first word; [31:16] = second word (0 when 16-bit)
// - fetch_is32     out  1         1 = 32-bit instruction
// - fetch_pc       out  PC_WIDTH  address of the first word of the instruction
// - branch_valid   in   1         redirect request
// - branch_target  in   PC_WIDTH  redirect address
// BEHAVIOUR
// - Reset: all sampled at a rising edge with reset=1.
//   - state=S_LO, pc=RESET_PC.
//   - fetch_valid=0, fetchoutput=0, fetch_is32=0, fetch_pc=0.
//   - imem_req=0 while reset is high.
// - imem_req = (state==S_LO || state==S_HI) && !reset. imem_addr = pc. Both are combinational from registers.
// - S_LO, on imem_ack:
//   - lo<=imem_rdata, ipc<=pc, pc<=pc+1.
//   - If imem_rdata[15]=1 -> S_HI.
//   - Else -> S_OUT with fetchoutput={16'h0,rdata}, fetch_is32=0, fetch_pc=pc, fetch_valid=1.
// - S_HI, on imem_ack:
//   - pc<=pc+1 -> S_OUT.
//   - fetchoutput={rdata,lo}, fetch_is32=1, fetch_pc=ipc, fetch_valid=1.
// - No ack: the state and imem_addr hold indefinitely (wait states allowed).
// - S_OUT:
//   - imem_req=0. Outputs are stable while fetch_ready=0.
//   - fetch_ready=1: fetch_valid<=0 -> S_LO.
// - Latency: 16-bit instruction valid 1 cycle after its ack; 32-bit valid 1 cycle after the second ack.
//   Throughput: at most 1 instruction per 2 cycles (16-bit) or 3 cycles (32-bit) at zero wait states.
// - Redirect (branch_valid=1) has priority over all other events except reset, in every state:
//   - pc<=branch_target, state<=S_LO, fetch_valid<=0.
//   - An imem_ack in the same cycle is consumed and its data discarded.
//   - In S_OUT with fetch_ready=1 in the same cycle, the transfer completes and the redirect also applies.
//   - A partial 32-bit instruction (lo captured) is discarded.
// - Wrap-around: pc=2^PC_WIDTH-1 increments to 0. A 32-bit instruction at the top address takes its second word from address 0. fetch_pc reports the top address.
// - Reset mid-operation:
//   - Reset overrides redirect and ack. An ack during reset is ignored.
//   - In the first cycle after reset is released, imem_req=1 and imem_addr=RESET_PC.
// - Never issue a new request while fetch_valid=1 (single-entry buffer, no prefetch).
// TESTING
// 1. 16-bit: RESET_PC=0, mem[0]=16'h5555, ack 0-wait -> fetch_valid=1, fetchoutput=32'h0000_5555, fetch_is32=0, fetch_pc=0; next imem_addr=1.
// 2. 32-bit: mem[1]=16'h8123, mem[2]=16'h4567 -> fetchoutput=32'h4567_8123, fetch_is32=1, fetch_pc=1; next imem_addr=3.
// 3. Backpressure and wait states:
//    - fetch_ready=0 for 5 cycles -> outputs unchanged, imem_req=0.
//    - ack delayed 3 cycles -> imem_addr stable, no advance.
// 4. Redirect: branch_valid=1, branch_target=16'h0040 in S_HI together with imem_ack -> data dropped, fetch_valid stays 0, next imem_addr=16'h0040.
// 5. Wrap: PC_WIDTH=4, 32-bit instruction at address 15 -> second request addr=0, fetch_pc=15, then imem_addr=1.
// 6. Reset in S_HI with ack high -> next cycle fetch_valid=0, fetchoutput=0; after release imem_req=1, imem_addr=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: reads 16-bit words over a req/ack handshake and assembles
// 16- or 32-bit instructions for the decoder through a single-entry output buffer.
module instruction_fetch #(
  parameter int unsigned          PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [15:0]         imem_rdata,
  output logic                fetch_valid,
  input  logic                fetch_ready,
  output logic [31:0]         fetchoutput,
  output logic                fetch_is32,
  output logic [PC_WIDTH-1:0] fetch_pc,
  input  logic                branch_valid,
  input  logic [PC_WIDTH-1:0] branch_target
);

  localparam logic [1:0] S_LO  = 2'd0;
  localparam logic [1:0] S_HI  = 2'd1;
  localparam logic [1:0] S_OUT = 2'd2;

  logic [1:0]          state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] ipc;
  logic [15:0]         lo;
  logic [PC_WIDTH-1:0] pc_next;

  // pc + 1 wraps naturally at the PC_WIDTH boundary
  assign pc_next   = pc + 1'b1;
  assign imem_req  = ((state == S_LO) || (state == S_HI)) && !reset;
  assign imem_addr = pc;

  // A redirect outranks everything but reset; any ack in that cycle is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_LO;
      pc          <= RESET_PC;
      ipc         <= '0;
      lo          <= '0;
      fetch_valid <= 1'b0;
      fetchoutput <= '0;
      fetch_is32  <= 1'b0;
      fetch_pc    <= '0;
    end else if (branch_valid) begin
      state       <= S_LO;
      pc          <= branch_target;
      fetch_valid <= 1'b0;
    end else begin
      case (state)
        S_LO: begin
          if (imem_ack) begin
            lo  <= imem_rdata;
            ipc <= pc;
            pc  <= pc_next;
            if (imem_rdata[15]) begin
              state <= S_HI;
            end else begin
              state       <= S_OUT;
              fetchoutput <= {16'h0000, imem_rdata};
              fetch_is32  <= 1'b0;
              fetch_pc    <= pc;
              fetch_valid <= 1'b1;
            end
          end
        end
        S_HI: begin
          if (imem_ack) begin
            pc          <= pc_next;
            state       <= S_OUT;
            fetchoutput <= {imem_rdata, lo};
            fetch_is32  <= 1'b1;
            fetch_pc    <= ipc;
            fetch_valid <= 1'b1;
          end
        end
        S_OUT: begin
          if (fetch_ready) begin
            fetch_valid <= 1'b0;
            state       <= S_LO;
          end
        end
        default: begin
          state       <= S_LO;
          fetch_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: one full-width instance and a
// 4-bit-PC instance used for the address wrap case.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetchoutput;
  logic        fetch_is32;
  logic [15:0] fetch_pc;
  logic        branch_valid;
  logic [15:0] branch_target;

  logic        reset_w;
  logic        req_w;
  logic [3:0]  addr_w;
  logic        ack_w;
  logic [15:0] rdata_w;
  logic        valid_w;
  logic        ready_w;
  logic [31:0] out_w;
  logic        is32_w;
  logic [3:0]  pc_w;

  logic [15:0] mem   [0:255];
  logic [15:0] mem_w [0:15];

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  assign imem_rdata = mem[imem_addr[7:0]];
  assign rdata_w    = mem_w[addr_w];

  instruction_fetch #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready), .fetchoutput(fetchoutput), .fetch_is32(fetch_is32),
    .fetch_pc(fetch_pc), .branch_valid(branch_valid), .branch_target(branch_target)
  );

  instruction_fetch #(.PC_WIDTH(4), .RESET_PC(4'hF)) dut_wrap (
    .clock(clock), .reset(reset_w), .imem_req(req_w), .imem_addr(addr_w),
    .imem_ack(ack_w), .imem_rdata(rdata_w), .fetch_valid(valid_w),
    .fetch_ready(ready_w), .fetchoutput(out_w), .fetch_is32(is32_w),
    .fetch_pc(pc_w), .branch_valid(1'b0), .branch_target(4'h0)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_ack = 1'b0; fetch_ready = 1'b0;
    branch_valid = 1'b0; branch_target = 16'h0000;
    step(); step();
    compared++;
    if (fetch_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", fetch_valid); end
    compared++;
    if (fetchoutput !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_out: got %h expected 0", fetchoutput); end
    compared++;
    if (fetch_is32 !== 1'b0 || fetch_pc !== 16'h0) begin mismatched++; $display("[TB] FAIL reset_is32_pc: got %b/%h expected 0/0000", fetch_is32, fetch_pc); end
    compared++;
    if (imem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
    reset = 1'b0;
    #1;
    compared++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin mismatched++; $display("[TB] FAIL release_req: got %b/%h expected 1/0000", imem_req, imem_addr); end
  endtask

  task automatic test_16bit();
    mem[0] = 16'h5555;
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    compared++;
    if (fetch_valid !== 1'b1 || fetchoutput !== 32'h0000_5555) begin mismatched++; $display("[TB] FAIL s16_out: got %b/%h expected 1/00005555", fetch_valid, fetchoutput); end
    compared++;
    if (fetch_is32 !== 1'b0 || fetch_pc !== 16'h0000) begin mismatched++; $display("[TB] FAIL s16_is32_pc: got %b/%h expected 0/0000", fetch_is32, fetch_pc); end
    compared++;
    if (imem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL s16_req_in_out: got %b expected 0", imem_req); end
    fetch_ready = 1'b1;
    step();
    fetch_ready = 1'b0;
    compared++;
    if (fetch_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0001) begin mismatched++; $display("[TB] FAIL s16_next: got %b/%b/%h expected 0/1/0001", fetch_valid, imem_req, imem_addr); end
  endtask

  task automatic test_32bit();
    mem[1] = 16'h8123; mem[2] = 16'h4567;
    imem_ack = 1'b1;
    step();
    compared++;
    if (fetch_valid !== 1'b0 || imem_addr !== 16'h0002 || imem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL s32_hi: got %b/%h/%b expected 0/0002/1", fetch_valid, imem_addr, imem_req); end
    step();
    imem_ack = 1'b0;
    compared++;
    if (fetch_valid !== 1'b1 || fetchoutput !== 32'h4567_8123) begin mismatched++; $display("[TB] FAIL s32_out: got %b/%h expected 1/45678123", fetch_valid, fetchoutput); end
    compared++;
    if (fetch_is32 !== 1'b1 || fetch_pc !== 16'h0001) begin mismatched++; $display("[TB] FAIL s32_is32_pc: got %b/%h expected 1/0001", fetch_is32, fetch_pc); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      step();
      compared++;
      if (fetch_valid !== 1'b1 || fetchoutput !== 32'h4567_8123 || fetch_pc !== 16'h0001 || imem_req !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL backpressure_%0d: got %b/%h/%h/%b expected 1/45678123/0001/0", i, fetch_valid, fetchoutput, fetch_pc, imem_req);
      end
    end
    fetch_ready = 1'b1;
    step();
    fetch_ready = 1'b0;
    compared++;
    if (imem_addr !== 16'h0003 || fetch_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL s32_next: got %h/%b expected 0003/0", imem_addr, fetch_valid); end
  endtask

  task automatic test_wait_states();
    mem[3] = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      step();
      compared++;
      if (imem_addr !== 16'h0003 || imem_req !== 1'b1 || fetch_valid !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL wait_%0d: got %h/%b/%b expected 0003/1/0", i, imem_addr, imem_req, fetch_valid);
      end
    end
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    compared++;
    if (fetch_valid !== 1'b1 || fetchoutput !== 32'h0000_1234 || fetch_pc !== 16'h0003) begin mismatched++; $display("[TB] FAIL wait_out: got %b/%h/%h expected 1/00001234/0003", fetch_valid, fetchoutput, fetch_pc); end
    fetch_ready = 1'b1;
    step();
    fetch_ready = 1'b0;
    compared++;
    if (imem_addr !== 16'h0004) begin mismatched++; $display("[TB] FAIL wait_next: got %h expected 0004", imem_addr); end
  endtask

  task automatic test_redirect();
    mem[4] = 16'h8AAA; mem[5] = 16'h0BBB; mem[8'h40] = 16'h0777;
    imem_ack = 1'b1;
    step();
    branch_valid = 1'b1; branch_target = 16'h0040;
    step();
    branch_valid = 1'b0; imem_ack = 1'b0;
    compared++;
    if (fetch_valid !== 1'b0 || imem_addr !== 16'h0040 || imem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL redirect_hi: got %b/%h/%b expected 0/0040/1", fetch_valid, imem_addr, imem_req); end
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    compared++;
    if (fetchoutput !== 32'h0000_0777 || fetch_is32 !== 1'b0 || fetch_pc !== 16'h0040) begin mismatched++; $display("[TB] FAIL redirect_target: got %h/%b/%h expected 00000777/0/0040", fetchoutput, fetch_is32, fetch_pc); end
    fetch_ready = 1'b1; branch_valid = 1'b1; branch_target = 16'h0010;
    step();
    fetch_ready = 1'b0; branch_valid = 1'b0;
    compared++;
    if (fetch_valid !== 1'b0 || imem_addr !== 16'h0010 || imem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL redirect_out: got %b/%h/%b expected 0/0010/1", fetch_valid, imem_addr, imem_req); end
  endtask

  task automatic test_reset_mid();
    mem[8'h10] = 16'h8001;
    imem_ack = 1'b1;
    step();
    reset = 1'b1; branch_valid = 1'b1; branch_target = 16'h0020;
    step();
    compared++;
    if (fetch_valid !== 1'b0 || fetchoutput !== 32'h0 || imem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mid: got %b/%h/%b expected 0/00000000/0", fetch_valid, fetchoutput, imem_req); end
    reset = 1'b0; imem_ack = 1'b0; branch_valid = 1'b0;
    #1;
    compared++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_mid_release: got %b/%h expected 1/0000", imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    mem_w[15] = 16'h9111; mem_w[0] = 16'h2222;
    step();
    reset_w = 1'b0;
    #1;
    compared++;
    if (req_w !== 1'b1 || addr_w !== 4'hF) begin mismatched++; $display("[TB] FAIL wrap_start: got %b/%h expected 1/f", req_w, addr_w); end
    ack_w = 1'b1;
    step();
    compared++;
    if (addr_w !== 4'h0 || req_w !== 1'b1) begin mismatched++; $display("[TB] FAIL wrap_second_addr: got %h/%b expected 0/1", addr_w, req_w); end
    step();
    ack_w = 1'b0;
    compared++;
    if (valid_w !== 1'b1 || out_w !== 32'h2222_9111 || is32_w !== 1'b1 || pc_w !== 4'hF) begin mismatched++; $display("[TB] FAIL wrap_out: got %b/%h/%b/%h expected 1/22229111/1/f", valid_w, out_w, is32_w, pc_w); end
    ready_w = 1'b1;
    step();
    ready_w = 1'b0;
    compared++;
    if (addr_w !== 4'h1 || valid_w !== 1'b0) begin mismatched++; $display("[TB] FAIL wrap_next: got %h/%b expected 1/0", addr_w, valid_w); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 16; i++) mem_w[i] = 16'h0000;
    reset_w = 1'b1; ack_w = 1'b0; ready_w = 1'b0;
    test_reset();
    test_16bit();
    test_32bit();
    test_backpressure();
    test_wait_states();
    test_redirect();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
